// File: rtl/pkt_ctrl_arb_pkg.sv
// Shared types for the packet controller arbiter. Software decodes status using
// the same state encodings.
package pkt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_RD_DONE = 3'd2,
        ST_WR_DONE = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    // True while a read or write engine is working on the current transfer.
    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_RD_DONE);
    endfunction

endpackage

// File: rtl/pkt_ctrl_arb_rr_arbiter.sv
// Combinational round-robin selector: picks the first requesting channel
// after the one-hot last_grant position, wrapping around.
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] last_grant,
    output logic [NUM_CH-1:0] gnt
);

    localparam int IDX_W = $clog2(NUM_CH);

    logic [IDX_W-1:0] w_last_idx;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        w_last_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (last_grant[i]) w_last_idx = IDX_W'(i);
        end

        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            w_idx = IDX_W'((32'(w_last_idx) + off) % NUM_CH);
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_ctrl_arb.sv
// Packet controller: queues per-channel requests, grants them round-robin and
// sequences the read then write engines with a per-transfer timeout.
module pkt_ctrl_arb
    import pkt_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] new_request,
    input  logic              rd_ctrl_rdy,
    input  logic              wr_ctrl_rdy,
    output logic              rd_ctrl,
    output logic              wr_ctrl,
    output logic [NUM_CH-1:0] grant,
    output logic [NUM_CH-1:0] pending,
    output logic              done,
    output logic              timeout_err,
    output logic [2:0]        state_out
);

    localparam logic [CNT_W-1:0]  TO_VAL   = CNT_W'(TIMEOUT_CYC);
    localparam logic [NUM_CH-1:0] LAST_RST = NUM_CH'(1) << (NUM_CH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_grant;
    logic [NUM_CH-1:0] r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_to_hit;
    logic [NUM_CH-1:0] w_gnt;
    logic [NUM_CH-1:0] w_clr;

    rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_rr (
        .req       (r_pending),
        .last_grant(r_last),
        .gnt       (w_gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Timeout takes priority over any rdy seen on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt == TO_VAL) ? r_cnt : r_cnt + 1'b1;
        w_to_hit    = (w_cnt_nxt == TO_VAL);
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_to_hit)                       w_state_nxt = ST_TIMEOUT;
                else if (rd_ctrl_rdy && wr_ctrl_rdy) w_state_nxt = ST_WR_DONE;
                else if (rd_ctrl_rdy)                w_state_nxt = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                if (w_to_hit)         w_state_nxt = ST_TIMEOUT;
                else if (wr_ctrl_rdy) w_state_nxt = ST_WR_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_clr = ((r_state == ST_WR_DONE) || (r_state == ST_TIMEOUT)) ? r_grant : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_grant   <= '0;
            r_last    <= LAST_RST;
            r_cnt     <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | new_request;
            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_grant <= w_gnt;
                        r_last  <= w_gnt;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN, ST_RD_DONE: r_cnt <= w_cnt_nxt;
                default:            r_grant <= '0;
            endcase
        end
    end

    assign rd_ctrl     = (r_state == ST_RUN);
    assign wr_ctrl     = is_busy(r_state);
    assign done        = (r_state == ST_WR_DONE);
    assign timeout_err = (r_state == ST_TIMEOUT);
    assign state_out   = r_state;
    assign grant       = r_grant;
    assign pending     = r_pending;

endmodule

// File: tb/tb_pkt_ctrl_arb.sv
// Randomized and directed bench for pkt_ctrl_arb, checked cycle by cycle
// against a transfer-level reference model.
module tb_pkt_ctrl_arb;

    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] new_request;
    logic         rd_ctrl_rdy;
    logic         wr_ctrl_rdy;
    logic         rd_ctrl;
    logic         wr_ctrl;
    logic [N-1:0] grant;
    logic [N-1:0] pending;
    logic         done;
    logic         timeout_err;
    logic [2:0]   state_out;

    int n_vec = 0;
    int n_err = 0;

    // reference model: phase 0..4, serviced channel, last channel, age in cycles
    int           m_st;
    int           m_ch;
    int           m_ptr;
    int           m_age;
    logic [N-1:0] m_pend;

    pkt_ctrl_arb #(
        .NUM_CH     (N),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .new_request(new_request),
        .rd_ctrl_rdy(rd_ctrl_rdy),
        .wr_ctrl_rdy(wr_ctrl_rdy),
        .rd_ctrl    (rd_ctrl),
        .wr_ctrl    (wr_ctrl),
        .grant      (grant),
        .pending    (pending),
        .done       (done),
        .timeout_err(timeout_err),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_ch   = 0;
        m_ptr  = N - 1;
        m_age  = 0;
        m_pend = '0;
    endtask

    task automatic compare_all();
        logic [N-1:0] g;
        g = (m_st == 0) ? '0 : N'(1 << m_ch);
        chk("state",   32'(state_out),   32'(m_st));
        chk("grant",   32'(grant),       32'(g));
        chk("pending", 32'(pending),     32'(m_pend));
        chk("rd_ctrl", 32'(rd_ctrl),     32'(m_st == 1));
        chk("wr_ctrl", 32'(wr_ctrl),     32'(m_st == 1 || m_st == 2));
        chk("done",    32'(done),        32'(m_st == 3));
        chk("tmo_err", 32'(timeout_err), 32'(m_st == 4));
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic rd, input logic wr);
        logic [N-1:0] np;
        bit           found;
        int           c;
        np = m_pend;
        if (m_st == 3 || m_st == 4) np = np & ~(N'(1) << m_ch);
        np = np | req;
        case (m_st)
            0: begin
                if (m_pend != 0) begin
                    found = 0;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_ptr + k) % N;
                        if (!found && ((m_pend >> c) & 1) != 0) begin
                            found = 1;
                            m_ch  = c;
                        end
                    end
                    m_ptr = m_ch;
                    m_age = 0;
                    m_st  = 1;
                end
            end
            1: begin
                m_age++;
                if (m_age >= TO)    m_st = 4;
                else if (rd && wr)  m_st = 3;
                else if (rd)        m_st = 2;
            end
            2: begin
                m_age++;
                if (m_age >= TO) m_st = 4;
                else if (wr)     m_st = 3;
            end
            default: m_st = 0;
        endcase
        m_pend = np;
    endtask

    // Called at a falling edge: check, apply inputs, advance model, next falling edge.
    task automatic drive(input logic [N-1:0] req, input logic rd, input logic wr);
        compare_all();
        new_request = req;
        rd_ctrl_rdy = rd;
        wr_ctrl_rdy = wr;
        model_step(req, rd, wr);
        @(negedge clk);
    endtask

    task automatic wait_state(input int target, input int budget);
        int n;
        n = 0;
        while (m_st != target && n < budget) begin
            drive('0, 1'b0, 1'b0);
            n++;
        end
        chk("wait_state", 32'(state_out), 32'(target));
    endtask

    initial begin
        int p_rd;
        int p_wr;
        logic [N-1:0] rq;

        reset       = 1'b0;
        new_request = '0;
        rd_ctrl_rdy = 1'b0;
        wr_ctrl_rdy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset = 1'b1;

        // round-robin from reset, simultaneous rdy skips RD_DONE
        drive(4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            wait_state(1, 4);
            chk("rr_grant", 32'(grant), 32'(1 << k));
            drive('0, 1'b1, 1'b1);
            chk("both_rdy_state", 32'(state_out), 32'd3);
            chk("both_rdy_done", 32'(done), 32'd1);
            drive('0, 1'b0, 1'b0);
            chk("back_idle", 32'(state_out), 32'd0);
        end

        // single request: grant two cycles after the request
        drive(4'b0010, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        chk("single_grant", 32'(grant), 32'h2);
        chk("single_rd", 32'(rd_ctrl), 32'd1);
        chk("single_wr", 32'(wr_ctrl), 32'd1);
        drive('0, 1'b0, 1'b1);
        chk("wr_ignored_in_run", 32'(state_out), 32'd1);
        drive('0, 1'b1, 1'b0);
        chk("rd_done_state", 32'(state_out), 32'd2);
        drive('0, 1'b0, 1'b1);
        chk("single_done", 32'(done), 32'd1);
        drive('0, 1'b0, 1'b0);
        chk("single_pend_clr", 32'(pending), 32'd0);

        // timeout exactly TO cycles after RUN entry
        drive(4'b0100, 1'b0, 1'b0);
        wait_state(1, 4);
        repeat (TO) drive('0, 1'b0, 1'b0);
        chk("to_state", 32'(state_out), 32'd4);
        chk("to_err", 32'(timeout_err), 32'd1);
        drive('0, 1'b0, 1'b0);
        chk("to_pend_clr", 32'(pending), 32'd0);

        // re-request while channel 0 is in WR_DONE
        drive(4'b0011, 1'b0, 1'b0);
        wait_state(1, 4);
        chk("rereq_first", 32'(grant), 32'h1);
        drive('0, 1'b1, 1'b1);
        drive(4'b0001, 1'b0, 1'b0);
        chk("rereq_pend", 32'(pending), 32'h3);
        wait_state(1, 4);
        chk("rereq_second", 32'(grant), 32'h2);
        drive('0, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b0);
        wait_state(1, 4);
        chk("rereq_third", 32'(grant), 32'h1);
        drive('0, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b0);

        // asynchronous reset while in RD_DONE
        drive(4'b0001, 1'b0, 1'b0);
        wait_state(1, 4);
        drive('0, 1'b1, 1'b0);
        chk("pre_rst_state", 32'(state_out), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("arst_state", 32'(state_out), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_pend", 32'(pending), 32'd0);
        chk("arst_wr", 32'(wr_ctrl), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        rd_ctrl_rdy = 1'b0;
        wr_ctrl_rdy = 1'b0;
        repeat (3) drive('0, 1'b0, 1'b1);

        // randomized traffic with varying engine latency
        for (int blk = 0; blk < 8; blk++) begin
            p_rd = $urandom_range(5, 70);
            p_wr = $urandom_range(5, 70);
            for (int i = 0; i < 200; i++) begin
                rq = ($urandom_range(0, 99) < 15) ? N'($urandom) : '0;
                drive(rq, ($urandom_range(0, 99) < p_rd), ($urandom_range(0, 99) < p_wr));
            end
        end
        compare_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_ctrl_arb.md
PKT_CTRL_ARB -- requirements
Module: pkt_ctrl_arb

Interface
REQ-001 Parameter NUM_CH, default 4, number of request channels (2..16).
REQ-002 Parameter TIMEOUT_CYC, default 1024, maximum cycles spent in RUN plus RD_DONE per transfer (>=2).
REQ-003 Parameter CNT_W, default $clog2(TIMEOUT_CYC+1), timeout counter width.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 new_request  in  NUM_CH  per-channel request; a 1 on any cycle queues that channel.
REQ-007 rd_ctrl_rdy  in  1  read engine finished current transfer.
REQ-008 wr_ctrl_rdy  in  1  write engine finished current transfer.
REQ-009 rd_ctrl  out  1  read engine enable.
REQ-010 wr_ctrl  out  1  write engine enable.
REQ-011 grant  out  NUM_CH  one-hot channel being serviced; all zero in IDLE.
REQ-012 pending  out  NUM_CH  queued-request register.
REQ-013 done  out  1  one-cycle pulse on successful completion.
REQ-014 timeout_err  out  1  one-cycle pulse on transfer abort.
REQ-015 state_out  out  3  current state encoding.

Function
REQ-016 States and encodings SHALL be IDLE=0, RUN=1, RD_DONE=2, WR_DONE=3, TIMEOUT=4; encodings 5-7 SHALL return to IDLE.
REQ-017 pending[i] SHALL set on new_request[i]=1 and clear when channel i's transfer leaves WR_DONE or TIMEOUT; simultaneous set and clear of the same bit: set wins.
REQ-018 IDLE: if pending (registered value) is non-zero, the FSM SHALL register a one-hot grant and enter RUN next cycle; otherwise remain IDLE.
REQ-019 Arbitration SHALL be round-robin: search starts at the channel after the last granted channel, wrapping from NUM_CH-1 to 0; after reset the search starts at channel 0.
REQ-020 A request arriving on cycle t SHALL be granted no earlier than cycle t+2 (one cycle to pending, one to grant).
REQ-021 RUN: rd_ctrl=1, wr_ctrl=1; rd_ctrl_rdy=1 and wr_ctrl_rdy=1 together -> WR_DONE; rd_ctrl_rdy=1 alone -> RD_DONE; else stay.
REQ-022 RD_DONE: rd_ctrl=0, wr_ctrl=1; wr_ctrl_rdy=1 -> WR_DONE; else stay.
REQ-023 wr_ctrl_rdy=1 in RUN without rd_ctrl_rdy SHALL be ignored (engine order is read before write).
REQ-024 WR_DONE: rd_ctrl=0, wr_ctrl=0, done=1 for exactly one cycle, then IDLE; grant held through WR_DONE.
REQ-025 Timeout counter SHALL clear on entry to RUN, increment each cycle in RUN and RD_DONE, and saturate; on reaching TIMEOUT_CYC the FSM SHALL enter TIMEOUT, overriding any rdy input that cycle.
REQ-026 TIMEOUT: rd_ctrl=0, wr_ctrl=0, timeout_err=1 for one cycle, then IDLE; the channel's pending bit clears as in REQ-017.
REQ-027 rd_ctrl, wr_ctrl, done, timeout_err, state_out SHALL be pure decodes of the registered state (no input-to-output combinational path).
REQ-028 grant SHALL be all zero in IDLE and one-hot in every other state.

Reset
REQ-029 reset=0 SHALL asynchronously force state=IDLE, pending=0, grant=0, counter=0, round-robin pointer=NUM_CH-1; all outputs 0.
REQ-030 Reset asserted mid-transfer SHALL abort without done or timeout_err pulse; the aborted request is discarded.
REQ-031 Deassertion SHALL be taken synchronously to clk by the first rising edge; first state change no earlier than that edge.

Structure
REQ-032 Package pkt_ctrl_pkg SHALL hold the state enum (3-bit) and its encodings, shared with pkt_ctrl and software-visible status decoding.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (parameter NUM_CH; inputs req, last_grant; output one-hot gnt), purely combinational.
REQ-034 Target size 150-300 lines of RTL including the sub-module.

Verification
REQ-035 Single request: NUM_CH=4, new_request=4'b0010 one cycle -> grant=0010 two cycles later, rd/wr_ctrl=1; rd_ctrl_rdy then wr_ctrl_rdy -> done pulse, pending=0, back to IDLE.
REQ-036 Round-robin: new_request=4'b1111 once -> grants 0001, 0010, 0100, 1000 in order, four done pulses.
REQ-037 Simultaneous rdy: both rdy=1 in RUN -> RD_DONE skipped, WR_DONE next cycle, state_out sequence 1,3,0.
REQ-038 Timeout: TIMEOUT_CYC=8, no rdy -> state_out=4 exactly 8 cycles after RUN entry, timeout_err one cycle, pending bit cleared.
REQ-039 Re-request during service: new_request[0]=1 while channel 0 in WR_DONE -> pending[0] stays 1, channel 0 serviced again after other pending channels.
REQ-040 Reset mid-RD_DONE: reset=0 -> outputs 0 immediately (asynchronously), pending=0, no done/timeout_err pulse.
